// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 UART transmitter behind the MMIO uart_t_* interface.
// A one-byte holding register feeds the shifter, so frames can run back to back.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_t_data,
  input  logic [1:0] uart_t_ctrl,
  output logic       uart_t_state,
  output logic       txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          hold_valid_q, hold_valid_d;
  logic [1:0]    ctrl_prev_q, ctrl_prev_d;
  logic          txd_q, txd_d;

  logic send_evt;
  logic abort;
  logic bit_end;
  logic transfer;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    ctrl_prev_d  = uart_t_ctrl;
    transfer     = 1'b0;

    send_evt = (uart_t_ctrl == 2'b01) && (ctrl_prev_q != 2'b01);
    abort    = (uart_t_ctrl == 2'b10);
    bit_end  = (cnt_q == CNT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (hold_valid_q) transfer = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (hold_valid_q) transfer = 1'b1;
          else state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (transfer) begin
      state_d      = S_START;
      cnt_d        = '0;
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
    end

    // a send landing on the draining cycle still finds a free slot
    if (send_evt && (!hold_valid_q || transfer)) begin
      hold_data_d  = uart_t_data;
      hold_valid_d = 1'b1;
    end

    if (abort) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
    end

    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      ctrl_prev_q  <= 2'b00;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      ctrl_prev_q  <= ctrl_prev_d;
      txd_q        <= txd_d;
    end
  end

  assign txd          = txd_q;
  assign uart_t_state = hold_valid_q;

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

UART transmit peripheral on the far side of the processor's `uart_t_*` MMIO interface. The memory-mapped I/O block presents a byte on `uart_t_data` and issues a send command on `uart_t_ctrl`; this block buffers the byte and serialises it onto `txd` as 8N1. It reports buffer-full status back on `uart_t_state`. A one-entry holding register in front of the shift register lets software queue the next byte while the current frame is on the line.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `uart_t_data`  in  8  byte to transmit; sampled only on an accepted send.
- `uart_t_ctrl`  in  2  command from MMIO: 2'b00 none, 2'b01 send, 2'b10 abort, 2'b11 reserved (treated as none).
- `uart_t_state`  out  1  1 = holding register full, so a send is ignored; 0 = a send will be accepted.
- `txd`  out  1  serial output, registered, idle high.

## Operation
- Frame format: start bit (0), then data bits 0..7 LSB first, then one stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` cycles, so one frame is 10·`CLKS_PER_BIT` cycles.
- Send detection is edge-based. `send_evt` = (`uart_t_ctrl`==2'b01) and (the previous cycle's `uart_t_ctrl`≠2'b01). Holding 2'b01 for many cycles therefore produces one event. The previous-ctrl register resets to 2'b00.
- Holding register (`hold_data`, `hold_valid`):
  - On `send_evt` with `hold_valid`=0: load `uart_t_data`, set `hold_valid`.
  - On `send_evt` with `hold_valid`=1: the byte is dropped and no state changes.
- Shifter FSM states:
  - IDLE: `txd`=1. If `hold_valid`, move the byte into the shift register, clear `hold_valid`, go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles.
    - At the end of STOP, if `hold_valid`, transfer the byte and go directly to START with no idle gap.
    - Otherwise go to IDLE.
- Bit-timer counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`−1, wraps to 0 on each bit boundary, and resets to 0 on every state entry.
- Abort (2'b10, level, every cycle it is present):
  - Clears `hold_valid`, the FSM goes to IDLE, the counter goes to 0, `txd`=1 after the edge.
  - A partial frame is truncated.
- Simultaneous events:
  - Abort always wins over transfer. A send cannot coincide with an abort, because it is the same ctrl bus.
  - `send_evt` in the same cycle that the shifter drains `hold_valid`: the transfer happens and the new byte is loaded. `hold_valid` stays 1 and the new byte is in the holding register.
- `uart_t_state` = `hold_valid` (registered).
- Reset values: `txd`=1, `uart_t_state`=0, FSM=IDLE, counter=0, shift register and `hold_data`=0, previous ctrl=2'b00.

## Timing
- The send command is sampled at edge N.
- `uart_t_state`=1 after edge N.
- If the shifter is idle, the transfer happens at edge N+1:
  - `uart_t_state`=0 and `txd`=0 after edge N+1.
  - The start bit spans edges N+1..N+1+`CLKS_PER_BIT`.
- Bit k of the data (k=0..7) begins at edge N+1+(k+1)·`CLKS_PER_BIT`.
- The stop bit begins at N+1+9·`CLKS_PER_BIT`; `txd` returns to 1 there.
- The FSM reaches IDLE at N+1+10·`CLKS_PER_BIT`.
- Back-to-back: with the holding register full, the next start bit begins at exactly the edge where the stop bit ends. The line shows exactly `CLKS_PER_BIT` high cycles between frames.
- Abort latency: one edge.
- Send while a frame is in progress: `uart_t_state` rises after the sampling edge and falls on the edge the next frame starts.

## Test plan
Run with `CLKS_PER_BIT`=4.
1. Reset, then hold `uart_t_ctrl`=00 for 20 cycles: `txd`=1 and `uart_t_state`=0 throughout.
2. Send 8'hA5 at edge N:
   - `uart_t_state` is high for exactly one cycle.
   - `txd` from edge N+1 reads, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, then 1.
   - Idle at N+41.
3. Send 8'h55, then 8'h0F two cycles later:
   - The second byte is accepted.
   - The frames are contiguous: exactly 4 high cycles between them, 80 cycles total from the first transfer.
4. Overflow:
   - Send 8'h11; while 8'h11 is shifting, send 8'h22 and then 8'h33.
   - 8'h33 is dropped because `uart_t_state`=1 at its send.
   - The line carries only 8'h11 and 8'h22.
5. Hold `uart_t_ctrl`=01 for 100 cycles with data 8'h3C: exactly one frame of 8'h3C is transmitted.
6. Abort:
   - Send 8'hFF and 8'h00, then abort during data bit 3 of the first frame.
   - `txd`=1 after the next edge, `uart_t_state`=0, no further frames.
   - Apply the synchronous reset mid-frame: same result.
